// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel programmable clock-enable / slow-clock generator
// Divisor writes are staged in div_pend and swapped in only at a period boundary.
module clk_div_gen #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 134217728,
    parameter int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                sync,
    input  logic                cfg_valid,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic                cfg_ready,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] slow_clk
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0]    cnt_q      [CHANNELS];
    logic [CNT_W-1:0]    cnt_d      [CHANNELS];
    logic [CNT_W-1:0]    div_cur_q  [CHANNELS];
    logic [CNT_W-1:0]    div_cur_d  [CHANNELS];
    logic [CNT_W-1:0]    div_pend_q [CHANNELS];
    logic [CNT_W-1:0]    div_pend_d [CHANNELS];
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] slow_q, slow_d;
    logic [CHANNELS-1:0] accept;
    logic [CNT_W-1:0]    cfg_div_eff;

    // Out-of-range selects stay ready so the write is silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_sel == SEL_W'(i)) cfg_ready = ~pend_q[i];
        end
    end

    always_comb begin
        cfg_div_eff = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = cfg_valid & cfg_ready & (cfg_sel == SEL_W'(i));
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        tick_d     = tick_q;
        slow_d     = slow_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b0;
                slow_d[i] = 1'b0;
                if (pend_q[i]) begin
                    div_cur_d[i] = div_pend_q[i];
                    pend_d[i]    = 1'b0;
                end
            end else if (!ch_en[i]) begin
                tick_d[i] = 1'b0;
                if (pend_q[i]) begin
                    div_cur_d[i] = div_pend_q[i];
                    pend_d[i]    = 1'b0;
                    cnt_d[i]     = '0;
                end
            end else if (cnt_q[i] == div_cur_q[i] - CNT_W'(1)) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                slow_d[i] = ~slow_q[i];
                if (pend_q[i]) begin
                    div_cur_d[i] = div_pend_q[i];
                    pend_d[i]    = 1'b0;
                end
            end else begin
                cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                tick_d[i] = 1'b0;
            end
            // Accept only happens when nothing is pending, so it never races the swap above.
            if (accept[i]) begin
                div_pend_d[i] = cfg_div_eff;
                pend_d[i]     = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]      <= '0;
                div_cur_q[i]  <= DIV_RST;
                div_pend_q[i] <= DIV_RST;
            end
            pend_q <= '0;
            tick_q <= '0;
            slow_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            slow_q     <= slow_d;
        end
    end

    assign tick     = tick_q;
    assign slow_clk = slow_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - directed self-checking bench for clk_div_gen
module tb_clk_div_gen;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] ch_en = 4'hF;
    logic       sync = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_sel = 3'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ready;
    logic [3:0] tick;
    logic [3:0] slow_clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    clk_div_gen #(
        .CHANNELS(4), .CNT_W(8), .DEFAULT_DIV(4), .SEL_W(3)
    ) dut (
        .CLK(CLK), .RST(RST), .ch_en(ch_en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .tick(tick), .slow_clk(slow_clk)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        step(2);
        total_cnt++;
        if (tick !== 4'h0) $display("FAIL reset_tick got=%h exp=0", tick); else pass_cnt++;
        total_cnt++;
        if (slow_clk !== 4'h0) $display("FAIL reset_slow got=%h exp=0", slow_clk); else pass_cnt++;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cfg_ready); else pass_cnt++;
        RST = 1'b0;
    endtask

    task automatic test_basic;
        step(3);
        total_cnt++;
        if (tick !== 4'h0) $display("FAIL basic_edge3_tick got=%h exp=0", tick); else pass_cnt++;
        step(1);
        total_cnt++;
        if (tick !== 4'hF) $display("FAIL basic_edge4_tick got=%h exp=f", tick); else pass_cnt++;
        step(1);
        total_cnt++;
        if (tick !== 4'h0 || slow_clk !== 4'hF)
            $display("FAIL basic_edge5 tick=%h slow=%h exp tick=0 slow=f", tick, slow_clk);
        else pass_cnt++;
        step(3);
        total_cnt++;
        if (tick !== 4'hF || slow_clk !== 4'h0)
            $display("FAIL basic_edge8 tick=%h slow=%h exp tick=f slow=0", tick, slow_clk);
        else pass_cnt++;
        step(4);
        total_cnt++;
        if (tick !== 4'hF || slow_clk !== 4'hF)
            $display("FAIL basic_edge12 tick=%h slow=%h exp tick=f slow=f", tick, slow_clk);
        else pass_cnt++;
    endtask

    // ch1 -> 3 written mid-period, ch2 -> 2 written on its terminal edge.
    task automatic test_write_stall;
        logic [3:0] exp_tick [12] = '{4'b0000, 4'b0000, 4'b0010, 4'b1101, 4'b0000, 4'b0110,
                                      4'b0000, 4'b1101, 4'b0010, 4'b0100, 4'b0000, 4'b1111};
        step(1);
        cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_div = 8'd3;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL wr_ready_before got=%b exp=1", cfg_ready); else pass_cnt++;
        step(1);
        cfg_div = 8'd7;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL wr_ready_after_accept got=%b exp=0", cfg_ready); else pass_cnt++;
        step(1);
        total_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL wr_second_stalled got=%b exp=0", cfg_ready); else pass_cnt++;
        cfg_sel = 3'd2; cfg_div = 8'd2;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL wr_ch2_ready got=%b exp=1", cfg_ready); else pass_cnt++;
        step(1);
        cfg_valid = 1'b0;
        total_cnt++;
        if (tick !== 4'hF || slow_clk !== 4'h0)
            $display("FAIL wr_terminal tick=%h slow=%h exp tick=f slow=0", tick, slow_clk);
        else pass_cnt++;
        cfg_sel = 3'd1;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL wr_ch1_ready_rise got=%b exp=1", cfg_ready); else pass_cnt++;
        cfg_sel = 3'd2;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL wr_ch2_pending got=%b exp=0", cfg_ready); else pass_cnt++;
        for (int k = 0; k < 12; k++) begin
            step(1);
            total_cnt++;
            if (tick !== exp_tick[k])
                $display("FAIL wr_seq_tick cyc=%0d got=%b exp=%b", k + 1, tick, exp_tick[k]);
            else pass_cnt++;
        end
        total_cnt++;
        if (slow_clk !== 4'b1101) $display("FAIL wr_seq_slow got=%b exp=1101", slow_clk); else pass_cnt++;
    endtask

    task automatic test_sync;
        logic [3:0] exp_tick [6] = '{4'b0000, 4'b0100, 4'b0010, 4'b0101, 4'b0000, 4'b1110};
        cfg_valid = 1'b1; cfg_sel = 3'd3; cfg_div = 8'd6;
        step(1);
        cfg_valid = 1'b0;
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        #1;
        total_cnt++;
        if (tick !== 4'h0 || slow_clk !== 4'h0)
            $display("FAIL sync_clear tick=%h slow=%h exp 0 0", tick, slow_clk);
        else pass_cnt++;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL sync_applies_pend ready=%b exp=1", cfg_ready); else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            step(1);
            total_cnt++;
            if (tick !== exp_tick[k])
                $display("FAIL sync_realign cyc=%0d got=%b exp=%b", k + 1, tick, exp_tick[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_div_zero;
        logic [2:0] exp_slow [3] = '{3'b001, 3'b000, 3'b001};
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        cfg_valid = 1'b1; cfg_sel = 3'd3; cfg_div = 8'd0;
        step(1);
        cfg_valid = 1'b0;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL div0_pending ready=%b exp=0", cfg_ready); else pass_cnt++;
        step(4);
        total_cnt++;
        if (tick[3] !== 1'b0) $display("FAIL div0_before_switch tick3=%b exp=0", tick[3]); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            step(1);
            total_cnt++;
            if (tick[3] !== 1'b1 || slow_clk[3] !== exp_slow[k][0])
                $display("FAIL div0_run cyc=%0d tick3=%b slow3=%b exp 1 %b",
                         k, tick[3], slow_clk[3], exp_slow[k][0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_enable;
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        step(2);
        ch_en = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            step(1);
            total_cnt++;
            if (tick[0] !== 1'b0 || slow_clk[0] !== 1'b0)
                $display("FAIL en_frozen cyc=%0d tick0=%b slow0=%b exp 0 0", k, tick[0], slow_clk[0]);
            else pass_cnt++;
        end
        ch_en = 4'hF;
        step(1);
        total_cnt++;
        if (tick[0] !== 1'b0) $display("FAIL en_late_pre tick0=%b exp=0", tick[0]); else pass_cnt++;
        step(1);
        total_cnt++;
        if (tick[0] !== 1'b1 || slow_clk[0] !== 1'b1)
            $display("FAIL en_late_tick tick0=%b slow0=%b exp 1 1", tick[0], slow_clk[0]);
        else pass_cnt++;
        ch_en = 4'b1110;
        cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_div = 8'd2;
        step(1);
        cfg_valid = 1'b0;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL en_pend_accept ready=%b exp=0", cfg_ready); else pass_cnt++;
        step(1);
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL en_disabled_load ready=%b exp=1", cfg_ready); else pass_cnt++;
        ch_en = 4'hF;
        step(1);
        total_cnt++;
        if (tick[0] !== 1'b0) $display("FAIL en_div2_pre tick0=%b exp=0", tick[0]); else pass_cnt++;
        step(1);
        total_cnt++;
        if (tick[0] !== 1'b1) $display("FAIL en_div2_tick tick0=%b exp=1", tick[0]); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_div = 8'd9;
        step(1);
        cfg_valid = 1'b0;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL rst_pend ready=%b exp=0", cfg_ready); else pass_cnt++;
        RST = 1'b1;
        step(1);
        total_cnt++;
        if (tick !== 4'h0 || slow_clk !== 4'h0 || cfg_ready !== 1'b1)
            $display("FAIL rst_mid tick=%h slow=%h ready=%b exp 0 0 1", tick, slow_clk, cfg_ready);
        else pass_cnt++;
        RST = 1'b0;
        step(3);
        total_cnt++;
        if (tick !== 4'h0) $display("FAIL rst_default_pre tick=%h exp=0", tick); else pass_cnt++;
        step(1);
        total_cnt++;
        if (tick !== 4'hF || slow_clk !== 4'hF)
            $display("FAIL rst_default tick=%h slow=%h exp f f", tick, slow_clk);
        else pass_cnt++;
    endtask

    task automatic test_bad_sel;
        cfg_valid = 1'b1; cfg_sel = 3'd5; cfg_div = 8'd1;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL badsel_ready got=%b exp=1", cfg_ready); else pass_cnt++;
        step(1);
        cfg_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cfg_sel = 3'(c);
            #1;
            total_cnt++;
            if (cfg_ready !== 1'b1) $display("FAIL badsel_no_pend ch=%0d ready=%b exp=1", c, cfg_ready);
            else pass_cnt++;
        end
        total_cnt++;
        if (tick !== 4'h0) $display("FAIL badsel_tick_quiet got=%h exp=0", tick); else pass_cnt++;
        step(3);
        total_cnt++;
        if (tick !== 4'hF) $display("FAIL badsel_period got=%h exp=f", tick); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_write_stall;
        test_sync;
        test_div_zero;
        test_enable;
        test_reset_mid;
        test_bad_sel;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock-enable generator for CLK-domain logic that needs slow rates (display refresh, debounce, step clocks). Each channel divides CLK by its own runtime-programmable divisor and produces a one-cycle tick plus a 50%-duty toggle output. Divisor changes apply glitch-free at the channel's next terminal count. With default parameters, channel 0 reproduces the legacy fixed CLK/2^28 slow clock.

## Interface
- CHANNELS, 4, number of independent divider channels (≥1)
- CNT_W, 32, counter and divisor width
- DEFAULT_DIV, 134217728 (2^27), reset divisor of every channel; toggle period = 2·DEFAULT_DIV
- SEL_W, max(1, clog2(CHANNELS)), derived; width of cfg_sel
- One clock; reset is synchronous and active-high:
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  synchronous active-high reset
- ch_en  in  CHANNELS  per-channel run enable (level)
- sync  in  1  one-cycle pulse; realigns all channels
- cfg_valid  in  1  divisor write request
- cfg_sel  in  SEL_W  target channel
- cfg_div  in  CNT_W  new divisor (0 treated as 1)
- cfg_ready  out  1  write can be accepted (combinational)
- tick  out  CHANNELS  one-CLK pulse per divided period (registered)
- slow_clk  out  CHANNELS  toggles on every tick (registered)

## Operation
- Per channel i: counter cnt, active divisor div_cur, pending divisor div_pend, flag pending.
- Reset: cnt=0, div_cur=DEFAULT_DIV, pending=0, tick=0, slow_clk=0; cfg_ready=1 after reset.
- Terminal count: ch_en[i]=1 and cnt==div_cur−1. On that edge: cnt←0, tick[i]←1, slow_clk[i]←~slow_clk[i]; if pending, div_cur←div_pend, pending←0.
- Otherwise, with ch_en[i]=1: cnt←cnt+1, tick[i]←0.
- ch_en[i]=0: cnt and slow_clk held, tick[i]←0; if pending, div_cur←div_pend, pending←0, cnt←0 on the next edge.
- Write handshake: accepted on an edge where cfg_valid & cfg_ready. cfg_ready = ~pending[cfg_sel]; for cfg_sel ≥ CHANNELS, cfg_ready=1 and the write is dropped. Accepted write: div_pend←(cfg_div==0 ? 1 : cfg_div), pending←1.
- Divisor 1: tick held high continuously, slow_clk toggles every cycle (CLK/2).
- sync=1: every channel cnt←0, tick←0, slow_clk←0, and any pending divisor is applied immediately. Writes presented on the same edge are still accepted into div_pend.
- Priority per edge: RST > sync > disabled-channel load > terminal count > increment.
- Accept and terminal count on the same edge for the same channel: the reload uses the old div_cur. The new divisor becomes active at the following terminal count, so exactly one more old-length period runs.
- Arithmetic is unsigned CNT_W; cnt never exceeds div_cur−1, so there is no wrap.

## Timing
- tick[i] first asserts in the cycle after the D-th active edge following RST release (D = div_cur). It then repeats every D cycles, each pulse 1 cycle wide.
- slow_clk[i] period = 2·D cycles. Its edges align with tick assertion.
- Divisor change latency: ≤ current period remaining + 0 cycles. There are no runt or stretched periods.
- cfg_ready falls the cycle after acceptance and rises the cycle after that channel's terminal count, sync, or disabled-load.
- RST mid-operation: all state returns to reset values on that edge, and pending writes are discarded.

## Test plan
- Parameters CHANNELS=4, CNT_W=8, DEFAULT_DIV=4. Release RST with ch_en=4'hF → every tick fires after edge 4 and every 4 cycles thereafter; slow_clk period 8; all channels phase-aligned.
- Write ch1 div=3 at cnt=1 → cfg_ready low until ch1 terminal count. That period stays 4, following periods are 3, with no glitch. A second write to ch1 is stalled, while a write to ch2 is accepted.
- Write ch3 div=0 → after the switch, tick[3] is constant 1 and slow_clk[3] toggles every cycle.
- ch_en[0]=0 for 5 cycles at cnt=2 → tick[0] and slow_clk[0] frozen; next tick[0] arrives 5 cycles later than nominal. Pending write while disabled → applied next edge with cnt=0.
- sync pulse at arbitrary phases → all slow_clk=0 and cnt=0 next cycle; ticks realign. RST mid-count with pending write → reset values, cfg_ready=1, DEFAULT_DIV restored.
- Accept on ch2's terminal edge → exactly one more 4-cycle period, then the new divisor. cfg_sel=5 with CHANNELS=4 → cfg_ready=1 and no channel changes.
